counter_datapath: RTL and testbench

Datapath for the up/down counter: it executes the command lines from the counter control FSM (`op`, `c_clr`, `c_ld`) on a count register and returns the status flags `z` and `m`. It also converts the count to two BCD digits and drives a multiplexed, active-low, two-digit 7-segment display. It sits between the control FSM and the board display pins.

---
 rtl/counter_datapath.sv | 120 ++++++++++++
 tb/tb_counter_datapath.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/counter_datapath.sv
// Up/down counter datapath: saturating count register, z/m status flags,
// BCD split and a two-digit multiplexed active-low 7-segment driver.
//
// Ports:
//   clk, reset    - clock; synchronous active-high reset
//   op            - 0 = increment, 1 = decrement (used when c_ld=1)
//   c_clr, c_ld   - clear / step commands (clear wins)
//   z, m          - count == 0 / count == MAX_VALUE
//   count         - count register
//   an, seg       - digit enables and segments, active-low {g..a}
module counter_datapath #(
  parameter int WIDTH     = 7,
  parameter int MAX_VALUE = 99,
  parameter int SCAN_DIV  = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op,
  input  logic             c_clr,
  input  logic             c_ld,
  output logic             z,
  output logic             m,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       an,
  output logic [6:0]       seg
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MAX_VALUE);
  localparam logic [PW-1:0]    PLAST = PW'(SCAN_DIV - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [3:0]       units_q, units_d;
  logic [3:0]       tens_q, tens_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             sel_q, sel_d;
  logic [31:0]      cval;

  function automatic logic [6:0] pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  always_comb begin
    count_d = count_q;
    if (c_clr) begin
      count_d = '0;
    end else if (c_ld) begin
      // Saturate at both ends instead of wrapping.
      if (!op && count_q < MAXV)
        count_d = count_q + 1'b1;
      else if (op && count_q != '0)
        count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    cval    = 32'(count_q);
    units_d = 4'(cval % 32'd10);
    tens_d  = 4'(cval / 32'd10);
  end

  always_comb begin
    pre_d = pre_q + 1'b1;
    sel_d = sel_q;
    if (pre_q == PLAST) begin
      pre_d = '0;
      sel_d = ~sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      units_q <= '0;
      tens_q  <= '0;
      pre_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      units_q <= units_d;
      tens_q  <= tens_d;
      pre_q   <= pre_d;
      sel_q   <= sel_d;
    end
  end

  assign count = count_q;
  assign z     = (count_q == '0);
  assign m     = (count_q == MAXV);

  always_comb begin
    an  = 2'b10;
    seg = pattern(units_q);
    if (sel_q) begin
      // Blank a leading zero in the tens slot.
      if (tens_q == 4'd0) begin
        an  = 2'b11;
        seg = 7'b1111111;
      end else begin
        an  = 2'b01;
        seg = pattern(tens_q);
      end
    end
  end

endmodule

// File: tb/tb_counter_datapath.sv
// Bench for counter_datapath: directed table, hand sequences and
// random commands against a reference model (two MAX_VALUE instances).
module tb_counter_datapath;

  localparam int SD = 4;
  localparam int MA = 99;
  localparam int MB = 12;

  logic       clk = 1'b0;
  logic       reset, op, c_clr, c_ld;
  logic       z_a, m_a, z_b, m_b;
  logic [6:0] count_a;
  logic [3:0] count_b;
  logic [1:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;

  counter_datapath #(.WIDTH(7), .MAX_VALUE(MA), .SCAN_DIV(SD)) dut_a (
    .clk(clk), .reset(reset), .op(op), .c_clr(c_clr), .c_ld(c_ld),
    .z(z_a), .m(m_a), .count(count_a), .an(an_a), .seg(seg_a)
  );

  counter_datapath #(.WIDTH(4), .MAX_VALUE(MB), .SCAN_DIV(SD)) dut_b (
    .clk(clk), .reset(reset), .op(op), .c_clr(c_clr), .c_ld(c_ld),
    .z(z_b), .m(m_b), .count(count_b), .an(an_b), .seg(seg_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: counts, displayed (one-cycle-old) counts, edges since reset.
  int cnt_a = 0, cnt_b = 0, disp_a = 0, disp_b = 0, k = 0;

  logic [6:0] PAT [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000};

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nxt(input int c, input int mx);
    if (c_clr) return 0;
    if (!c_ld) return c;
    if (!op) return (c < mx) ? c + 1 : c;
    return (c > 0) ? c - 1 : c;
  endfunction

  function automatic int sel_now();
    return (k / SD) % 2;
  endfunction

  function automatic int exp_an(input int d);
    if (sel_now() == 0) return 2;
    return (d / 10 == 0) ? 3 : 1;
  endfunction

  function automatic int exp_seg(input int d);
    if (sel_now() == 0) return int'(PAT[d % 10]);
    return (d / 10 == 0) ? 127 : int'(PAT[d / 10]);
  endfunction

  task automatic step();
    @(posedge clk);
    if (reset) begin
      cnt_a = 0; cnt_b = 0; disp_a = 0; disp_b = 0; k = 0;
    end else begin
      disp_a = cnt_a; disp_b = cnt_b; k++;
      cnt_a = nxt(cnt_a, MA);
      cnt_b = nxt(cnt_b, MB);
    end
    #1;
    chk("count_a", int'(count_a), cnt_a);
    chk("z_a", int'(z_a), int'(cnt_a == 0));
    chk("m_a", int'(m_a), int'(cnt_a == MA));
    chk("an_a", int'(an_a), exp_an(disp_a));
    chk("seg_a", int'(seg_a), exp_seg(disp_a));
    chk("count_b", int'(count_b), cnt_b);
    chk("z_b", int'(z_b), int'(cnt_b == 0));
    chk("m_b", int'(m_b), int'(cnt_b == MB));
    chk("an_b", int'(an_b), exp_an(disp_b));
    chk("seg_b", int'(seg_b), exp_seg(disp_b));
  endtask

  task automatic drive(input logic r, input logic cl, input logic ld,
                       input logic o);
    reset = r; c_clr = cl; c_ld = ld; op = o;
    step();
  endtask

  typedef struct {
    logic r, cl, ld, o;
    int   cnt;
    logic zz;
  } vec_t;

  vec_t tbl[$];

  initial begin
    reset = 1'b1; c_clr = 1'b1; c_ld = 1'b1; op = 1'b0;

    // Directed table: reset with commands, inc 3, dec 5, clear priority.
    tbl.push_back('{1, 1, 1, 0, 0, 1});
    tbl.push_back('{1, 1, 1, 1, 0, 1});
    tbl.push_back('{0, 0, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 1, 0, 2, 0});
    tbl.push_back('{0, 0, 1, 0, 3, 0});
    tbl.push_back('{0, 0, 1, 1, 2, 0});
    tbl.push_back('{0, 0, 1, 1, 1, 0});
    tbl.push_back('{0, 0, 1, 1, 0, 1});
    tbl.push_back('{0, 0, 1, 1, 0, 1});
    tbl.push_back('{0, 0, 1, 1, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 1});
    for (int i = 1; i <= 7; i++) tbl.push_back('{0, 0, 1, 0, i, 0});
    tbl.push_back('{0, 1, 1, 0, 0, 1});
    tbl.push_back('{0, 0, 1, 0, 1, 0});
    tbl.push_back('{0, 1, 0, 1, 0, 1});
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].cl, tbl[i].ld, tbl[i].o);
      chk("tbl_count", int'(count_a), tbl[i].cnt);
      chk("tbl_z", int'(z_a), int'(tbl[i].zz));
    end

    // Saturation at 12 with single-cycle pulses.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      drive(0, 0, 1, 0);
      drive(0, 0, 0, 0);
    end
    chk("sat_b_count", int'(count_b), 12);
    chk("sat_b_m", int'(m_b), 1);
    chk("sat_a_count", int'(count_a), 15);

    // Scan and decode at 42.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 42; i++) drive(0, 0, 1, 0);
    chk("scan_count", int'(count_a), 42);
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 0);

    // Blanking and BCD latency across 9 -> 10.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) drive(0, 0, 1, 0);
    for (int i = 0; i < 2 * SD + 2 && sel_now() == 0; i++)
      drive(0, 0, 0, 0);
    chk("blank_an", int'(an_a), 3);
    chk("blank_seg", int'(seg_a), 127);
    drive(0, 0, 1, 0);
    chk("step_count", int'(count_a), 10);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 2 * SD + 2 && sel_now() == 0; i++)
      drive(0, 0, 0, 0);
    chk("tens_an", int'(an_a), 1);
    chk("tens_seg", int'(seg_a), 7'b1111001);

    // Random commands with direction runs to reach both limits.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic dir;
      dir = ((i / 250) % 2) == 1;
      reset = ($urandom_range(0, 199) == 0);
      c_clr = ($urandom_range(0, 99) == 0);
      c_ld  = ($urandom_range(0, 3) != 0);
      op    = ($urandom_range(0, 9) == 0) ? ~dir : dir;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
